// File: rtl/riscv_fstage.sv
// RV64I instruction fetch stage: sequential fetch, pipelined req/gnt/rvalid memory port,
// in-order instruction buffer, stall and redirect handling. Optional perf counters: RISCV_FSTAGE_PERF_CNT_EN.
module riscv_fstage #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 2
) (
  input  logic        i_riscv_clk,
  input  logic        i_riscv_rst,
  input  logic        i_riscv_fstage_stall,
  input  logic        i_riscv_fstage_redirect,
  input  logic [63:0] i_riscv_fstage_redirect_pc,
  output logic        o_riscv_fstage_imem_req,
  output logic [63:0] o_riscv_fstage_imem_addr,
  input  logic        i_riscv_fstage_imem_gnt,
  input  logic        i_riscv_fstage_imem_rvalid,
  input  logic [31:0] i_riscv_fstage_imem_rdata,
  output logic        o_riscv_fstage_valid,
  output logic [31:0] o_riscv_fstage_inst,
  output logic [63:0] o_riscv_fstage_pc,
  output logic [63:0] o_riscv_fstage_pcplus4
`ifdef RISCV_FSTAGE_PERF_CNT_EN
  ,
  output logic [63:0] o_riscv_fstage_fetch_cnt,
  output logic [63:0] o_riscv_fstage_stall_cnt
`endif
);

  localparam int          PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // Handshakes: memory request transfers when req && gnt; response has no back-pressure (rvalid);
  // decode consumes the presented instruction when valid && !stall.
  logic [63:0]      fetch_pc;
  logic [63:0]      last_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] f_wr, f_rd, q_wr, q_rd;
  logic [63:0]      fifo_pc   [FIFO_DEPTH];
  logic [31:0]      fifo_inst [FIFO_DEPTH];
  logic [63:0]      infl_pc   [FIFO_DEPTH];

  logic             valid, pop, push, req, grant;
  logic [CNT_W:0]   used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    valid = (fifo_count != '0) && !i_riscv_fstage_redirect;
    pop   = valid && !i_riscv_fstage_stall;
    push  = i_riscv_fstage_imem_rvalid && (discard == '0) && !i_riscv_fstage_redirect;
    // A pop this cycle frees a slot, so it counts as credit for a new request.
    used  = {1'b0, outstanding} + {1'b0, fifo_count} - (CNT_W+1)'(pop);
    req   = !i_riscv_rst && !i_riscv_fstage_redirect && (used < (CNT_W+1)'(FIFO_DEPTH));
    grant = req && i_riscv_fstage_imem_gnt;
  end

  always_ff @(posedge i_riscv_clk) begin
    if (i_riscv_rst) begin
      fetch_pc    <= RESET_PC;
      last_pc     <= 64'h0;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      f_wr        <= '0;
      f_rd        <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
    end else begin
      if (grant) q_wr <= ptr_inc(q_wr);
      if (i_riscv_fstage_imem_rvalid) q_rd <= ptr_inc(q_rd);
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(i_riscv_fstage_imem_rvalid);
      if (valid) last_pc <= fifo_pc[f_rd];
      if (i_riscv_fstage_redirect) begin
        // Everything still pending after this cycle belongs to the old path.
        fetch_pc   <= i_riscv_fstage_redirect_pc & ~64'h3;
        discard    <= outstanding - CNT_W'(i_riscv_fstage_imem_rvalid);
        fifo_count <= '0;
        f_wr       <= '0;
        f_rd       <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 64'd4;
        if (i_riscv_fstage_imem_rvalid && (discard != '0)) discard <= discard - CNT_W'(1);
        if (push) f_wr <= ptr_inc(f_wr);
        if (pop) f_rd <= ptr_inc(f_rd);
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the counters above.
  always_ff @(posedge i_riscv_clk) begin
    if (grant) infl_pc[q_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[f_wr]   <= infl_pc[q_rd];
      fifo_inst[f_wr] <= i_riscv_fstage_imem_rdata;
    end
  end

  assign o_riscv_fstage_imem_req  = req;
  assign o_riscv_fstage_imem_addr = fetch_pc;
  assign o_riscv_fstage_valid     = valid;
  assign o_riscv_fstage_inst      = valid ? fifo_inst[f_rd] : NOP;
  assign o_riscv_fstage_pc        = valid ? fifo_pc[f_rd] : last_pc;
  assign o_riscv_fstage_pcplus4   = o_riscv_fstage_pc + 64'd4;

`ifdef RISCV_FSTAGE_PERF_CNT_EN
  logic [63:0] fetch_cnt, stall_cnt;

  always_ff @(posedge i_riscv_clk) begin
    if (i_riscv_rst) begin
      fetch_cnt <= 64'h0;
      stall_cnt <= 64'h0;
    end else begin
      if (pop && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 64'd1;
      if (valid && i_riscv_fstage_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 64'd1;
    end
  end

  assign o_riscv_fstage_fetch_cnt = fetch_cnt;
  assign o_riscv_fstage_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_riscv_fstage.sv
// Directed bench for riscv_fstage with an in-order, variable-latency instruction memory model.
module tb_riscv_fstage;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        imem_req, valid;
  logic [63:0] imem_addr, pc, pcplus4;
  logic [31:0] inst;
`ifdef RISCV_FSTAGE_PERF_CNT_EN
  logic [63:0] fetch_cnt, stall_cnt;
`endif

  riscv_fstage #(.RESET_PC(64'h0), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(2)) dut (
    .i_riscv_clk(clk),
    .i_riscv_rst(rst),
    .i_riscv_fstage_stall(stall),
    .i_riscv_fstage_redirect(redirect),
    .i_riscv_fstage_redirect_pc(redirect_pc),
    .o_riscv_fstage_imem_req(imem_req),
    .o_riscv_fstage_imem_addr(imem_addr),
    .i_riscv_fstage_imem_gnt(gnt),
    .i_riscv_fstage_imem_rvalid(rvalid),
    .i_riscv_fstage_imem_rdata(rdata),
    .o_riscv_fstage_valid(valid),
    .o_riscv_fstage_inst(inst),
    .o_riscv_fstage_pc(pc),
    .o_riscv_fstage_pcplus4(pcplus4)
`ifdef RISCV_FSTAGE_PERF_CNT_EN
    ,
    .o_riscv_fstage_fetch_cnt(fetch_cnt),
    .o_riscv_fstage_stall_cnt(stall_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: run time exceeded");
    $fatal(1, "watchdog");
  end

  int          total = 0, bad = 0;
  int          cyc = 0, lat = 1;
  bit          gnt_en = 1'b1, rst_nx = 1'b1;
  logic [63:0] pend_addr_q[$];
  int          pend_due_q[$];
  logic [63:0] exp_q[$];
  logic        s_req, s_valid, s_rvalid;
  logic [63:0] s_addr, s_pc, s_pcplus4;
  logic [31:0] s_inst;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h00A0_0413;
    else if (a == 64'h4) return 32'h0140_0493;
    else return {a[29:2], 4'h7};
  endfunction

  // One cycle: apply inputs after negedge, drive memory response, sample, model the handshake.
  task automatic step(input logic st, input logic rd, input logic [63:0] rpc);
    @(negedge clk);
    rst = rst_nx;
    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    gnt = gnt_en;
    if (!rst && pend_addr_q.size() > 0 && pend_due_q[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_word(pend_addr_q[0]);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'hDEAD_BEEF;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = valid; s_rvalid = rvalid;
    s_inst = inst; s_pc = pc; s_pcplus4 = pcplus4;
    if (rst) begin
      pend_addr_q.delete();
      pend_due_q.delete();
    end else begin
      if (rvalid) begin
        void'(pend_addr_q.pop_front());
        void'(pend_due_q.pop_front());
      end
      if (imem_req && gnt) begin
        pend_addr_q.push_back(imem_addr);
        pend_due_q.push_back(cyc + lat);
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int l);
    lat = l;
    gnt_en = 1'b1;
    rst_nx = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    rst_nx = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", s_req); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", s_valid); end
    total++; if (s_inst !== NOP) begin bad++; $display("FAIL reset_inst got=%h want=%h", s_inst, NOP); end
    total++; if (s_pc !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", s_pc); end
    total++; if (s_pcplus4 !== 64'h4) begin bad++; $display("FAIL reset_pcplus4 got=%h want=4", s_pcplus4); end
`ifdef RISCV_FSTAGE_PERF_CNT_EN
    total++; if (fetch_cnt !== 64'h0) begin bad++; $display("FAIL reset_fetch_cnt got=%0d want=0", fetch_cnt); end
`endif
  endtask

  task automatic test_first_fetch();
    do_reset(1);
    step(0, 0, 0);
    total++; if (s_req !== 1'b1 || s_addr !== 64'h0) begin bad++; $display("FAIL first_req got=%0b/%h want=1/0", s_req, s_addr); end
    step(0, 0, 0);
    total++; if (s_valid !== 1'b0 || s_addr !== 64'h4) begin bad++; $display("FAIL c2 got valid=%0b addr=%h want 0/4", s_valid, s_addr); end
    step(0, 0, 0);
    total++; if (s_valid !== 1'b1 || s_inst !== 32'h00A0_0413 || s_pc !== 64'h0 || s_pcplus4 !== 64'h4) begin
      bad++; $display("FAIL first_inst got v=%0b inst=%h pc=%h p4=%h want 1/00a00413/0/4", s_valid, s_inst, s_pc, s_pcplus4); end
    step(0, 0, 0);
    total++; if (s_valid !== 1'b1 || s_inst !== 32'h0140_0493 || s_pc !== 64'h4 || s_pcplus4 !== 64'h8) begin
      bad++; $display("FAIL second_inst got v=%0b inst=%h pc=%h p4=%h want 1/01400493/4/8", s_valid, s_inst, s_pc, s_pcplus4); end
  endtask

  task automatic test_back_to_back();
    do_reset(1);
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(64'(i * 4));
    step(0, 0, 0);
    step(0, 0, 0);
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid got=%0b want=0", s_valid); end
    for (int i = 0; i < 10; i++) begin
      logic [63:0] e;
      step(0, 0, 0);
      e = exp_q.pop_front();
      total++; if (s_valid !== 1'b1 || s_pc !== e || s_inst !== mem_word(e)) begin
        bad++; $display("FAIL b2b_stream[%0d] got v=%0b pc=%h inst=%h want 1/%h/%h", i, s_valid, s_pc, s_inst, e, mem_word(e)); end
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    repeat (4) step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      total++; if (s_valid !== 1'b1 || s_pc !== 64'h8 || s_inst !== mem_word(64'h8)) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%0b pc=%h inst=%h want 1/8/%h", i, s_valid, s_pc, s_inst, mem_word(64'h8)); end
      total++; if (s_req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%0b want=0", i, s_req); end
      total++; if (pend_addr_q.size() > FIFO_DEPTH) begin bad++; $display("FAIL stall_outstanding got=%0d want<=%0d", pend_addr_q.size(), FIFO_DEPTH); end
    end
    for (int i = 0; i < 3; i++) begin
      logic [63:0] e;
      e = 64'h8 + 64'(i * 4);
      step(0, 0, 0);
      total++; if (s_valid !== 1'b1 || s_pc !== e) begin bad++; $display("FAIL stall_release[%0d] got v=%0b pc=%h want 1/%h", i, s_valid, s_pc, e); end
    end
`ifdef RISCV_FSTAGE_PERF_CNT_EN
    total++; if (stall_cnt !== 64'd3) begin bad++; $display("FAIL stall_cnt got=%0d want=3", stall_cnt); end
    total++; if (fetch_cnt !== 64'd4) begin bad++; $display("FAIL fetch_cnt got=%0d want=4", fetch_cnt); end
`endif
  endtask

  task automatic test_redirect_drop();
    bit seen_req, seen_valid;
    do_reset(3);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 64'h1003);
    total++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin bad++; $display("FAIL redir_cycle got req=%0b valid=%0b want 0/0", s_req, s_valid); end
    total++; if (pend_addr_q.size() != 2) begin bad++; $display("FAIL redir_outstanding got=%0d want=2", pend_addr_q.size()); end
    seen_req = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20 && !seen_valid; i++) begin
      step(0, 0, 0);
      if (s_req && !seen_req) begin
        seen_req = 1'b1;
        total++; if (s_addr !== 64'h1000) begin bad++; $display("FAIL redir_first_addr got=%h want=1000", s_addr); end
      end
      if (s_valid) begin
        seen_valid = 1'b1;
        total++; if (s_pc !== 64'h1000 || s_inst !== mem_word(64'h1000)) begin
          bad++; $display("FAIL redir_first_inst got pc=%h inst=%h want 1000/%h", s_pc, s_inst, mem_word(64'h1000)); end
      end
    end
    total++; if (!seen_valid) begin bad++; $display("FAIL redir_timeout got=no valid want=valid within 20 cycles"); end
  endtask

  task automatic test_redirect_rvalid_stall();
    do_reset(1);
    repeat (3) step(0, 0, 0);
    step(1, 1, 64'h2000);
    total++; if (s_rvalid !== 1'b1) begin bad++; $display("FAIL rrs_rvalid got=%0b want=1", s_rvalid); end
    total++; if (s_valid !== 1'b0 || s_req !== 1'b0) begin bad++; $display("FAIL rrs_cycle got valid=%0b req=%0b want 0/0", s_valid, s_req); end
    step(0, 0, 0);
    total++; if (s_req !== 1'b1 || s_addr !== 64'h2000 || s_valid !== 1'b0) begin
      bad++; $display("FAIL rrs_refetch got req=%0b addr=%h valid=%0b want 1/2000/0", s_req, s_addr, s_valid); end
    step(0, 0, 0);
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rrs_stale got valid=%0b pc=%h want valid=0", s_valid, s_pc); end
    step(0, 0, 0);
    total++; if (s_valid !== 1'b1 || s_pc !== 64'h2000 || s_inst !== mem_word(64'h2000)) begin
      bad++; $display("FAIL rrs_target got v=%0b pc=%h inst=%h want 1/2000/%h", s_valid, s_pc, s_inst, mem_word(64'h2000)); end
  endtask

  task automatic test_double_redirect();
    do_reset(1);
    repeat (3) step(0, 0, 0);
    step(0, 1, 64'h3000);
    step(0, 1, 64'h4006);
    total++; if (s_valid !== 1'b0 || s_req !== 1'b0) begin bad++; $display("FAIL dbl_second got valid=%0b req=%0b want 0/0", s_valid, s_req); end
    step(0, 0, 0);
    total++; if (s_req !== 1'b1 || s_addr !== 64'h4004) begin bad++; $display("FAIL dbl_addr got req=%0b addr=%h want 1/4004", s_req, s_addr); end
    step(0, 0, 0);
    step(0, 0, 0);
    total++; if (s_valid !== 1'b1 || s_pc !== 64'h4004) begin bad++; $display("FAIL dbl_target got v=%0b pc=%h want 1/4004", s_valid, s_pc); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, 0, 0);
    total++; if (s_req !== 1'b1 || s_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_req got req=%0b addr=%h want 1/fffffffffffffffc", s_req, s_addr); end
    step(0, 0, 0);
    total++; if (s_addr !== 64'h0) begin bad++; $display("FAIL wrap_addr got=%h want=0", s_addr); end
    step(0, 0, 0);
    total++; if (s_valid !== 1'b1 || s_pc !== 64'hFFFF_FFFF_FFFF_FFFC || s_pcplus4 !== 64'h0 || s_inst !== mem_word(64'hFFFF_FFFF_FFFF_FFFC)) begin
      bad++; $display("FAIL wrap_pcplus4 got v=%0b pc=%h p4=%h inst=%h want 1/fffffffffffffffc/0/%h", s_valid, s_pc, s_pcplus4, s_inst, mem_word(64'hFFFF_FFFF_FFFF_FFFC)); end
  endtask

  task automatic test_gnt_low();
    do_reset(1);
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      total++; if (s_req !== 1'b1 || s_addr !== 64'h0) begin bad++; $display("FAIL gnt_low[%0d] got req=%0b addr=%h want 1/0", i, s_req, s_addr); end
    end
    gnt_en = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    total++; if (s_req !== 1'b1 || s_addr !== 64'h4) begin bad++; $display("FAIL gnt_resume got req=%0b addr=%h want 1/4", s_req, s_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset(3);
    step(0, 0, 0);
    step(0, 0, 0);
    rst_nx = 1'b1;
    step(0, 0, 0);
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got=%0b want=0", s_req); end
    rst_nx = 1'b0;
    step(0, 0, 0);
    total++; if (s_valid !== 1'b0 || s_inst !== NOP || s_pc !== 64'h0 || s_pcplus4 !== 64'h4) begin
      bad++; $display("FAIL mid_rst_out got v=%0b inst=%h pc=%h p4=%h want 0/00000013/0/4", s_valid, s_inst, s_pc, s_pcplus4); end
    total++; if (s_req !== 1'b1 || s_addr !== 64'h0) begin bad++; $display("FAIL mid_rst_refetch got req=%0b addr=%h want 1/0", s_req, s_addr); end
`ifdef RISCV_FSTAGE_PERF_CNT_EN
    total++; if (fetch_cnt !== 64'h0 || stall_cnt !== 64'h0) begin bad++; $display("FAIL mid_rst_cnt got=%0d/%0d want 0/0", fetch_cnt, stall_cnt); end
`endif
    repeat (3) step(0, 0, 0);
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_stale got valid=%0b pc=%h want 0", s_valid, s_pc); end
    step(0, 0, 0);
    total++; if (s_valid !== 1'b1 || s_pc !== 64'h0 || s_inst !== 32'h00A0_0413) begin
      bad++; $display("FAIL mid_rst_first got v=%0b pc=%h inst=%h want 1/0/00a00413", s_valid, s_pc, s_inst); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_stall();
    test_redirect_drop();
    test_redirect_rvalid_stall();
    test_double_redirect();
    test_wrap();
    test_gnt_low();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
